tile_sequencer: RTL and testbench

- Parametrised successor to the fixed-size TPU control top.
- Walks a matmul as V output-column tiles × U reduction tiles × R activation rows.
- For each (v,u) pair it requests one weight tile, streams R unified-buffer reads, and issues accumulator writes delayed to match the systolic pipeline. Writes overwrite on u=0 and accumulate on u>0.
- Sits between the host command interface and the unified buffer, weight FIFO and accumulator.

---
 rtl/tile_sequencer_if.sv | 40 ++++
 rtl/tile_sequencer.sv | 143 ++++++++++++++
 tb/tb_tile_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_sequencer_if.sv
// Host command, unified-buffer, weight-FIFO and accumulator signals of the tile sequencer.
// Latency: none; this is a plain bundle of wires.
// Backpressure: stall_i freezes the sequencer and weight_rdy_i gates each weight tile.
interface tile_sequencer_if #(
   parameter int DIM_W      = 7,
   parameter int UB_ADDR_W  = 12,
   parameter int ACC_ADDR_W = 10
);
   logic                  start_i;
   logic [DIM_W-1:0]      v_tiles_i;
   logic [DIM_W-1:0]      u_tiles_i;
   logic [DIM_W-1:0]      rows_i;
   logic [UB_ADDR_W-1:0]  ub_base_i;
   logic [ACC_ADDR_W-1:0] acc_base_i;
   logic                  weight_rdy_i;
   logic                  stall_i;
   logic                  weight_req_o;
   logic                  ub_rd_en_o;
   logic [UB_ADDR_W-1:0]  ub_addr_o;
   logic                  mac_compute_o;
   logic                  acc_wr_en_o;
   logic [ACC_ADDR_W-1:0] acc_addr_o;
   logic                  acc_add_o;
   logic                  busy_o;
   logic                  done_o;

   // Host / surrounding datapath side
   modport master (
      output start_i, v_tiles_i, u_tiles_i, rows_i, ub_base_i, acc_base_i, weight_rdy_i, stall_i,
      input  weight_req_o, ub_rd_en_o, ub_addr_o, mac_compute_o, acc_wr_en_o, acc_addr_o,
             acc_add_o, busy_o, done_o
   );

   // Sequencer side
   modport slave (
      input  start_i, v_tiles_i, u_tiles_i, rows_i, ub_base_i, acc_base_i, weight_rdy_i, stall_i,
      output weight_req_o, ub_rd_en_o, ub_addr_o, mac_compute_o, acc_wr_en_o, acc_addr_o,
             acc_add_o, busy_o, done_o
   );
endinterface

// File: rtl/tile_sequencer.sv
// Walks a matmul as V column tiles x U reduction tiles x R rows, driving UB reads and accumulator writes.
// Latency: each UB read produces its accumulator write PIPE_LAT unstalled cycles later; done_o one cycle after the last write.
// Backpressure: stall_i freezes row streaming and the write delay line; weight_rdy_i gates the start of every tile.
module tile_sequencer #(
   parameter int MUL_SIZE   = 16,
   parameter int DIM_W      = 7,
   parameter int UB_ADDR_W  = 12,
   parameter int ACC_ADDR_W = 10,
   parameter int PIPE_LAT   = 2 * MUL_SIZE
) (
   input logic             clk_i,
   input logic             rst_i,
   tile_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WAIT_W, STREAM, DRAIN, DONE} state_t;

   typedef struct packed {
      logic                  valid;
      logic [ACC_ADDR_W-1:0] addr;
      logic                  add;
   } acc_ent_t;

   state_t                state;
   logic [DIM_W-1:0]      v_tiles, u_tiles, rows;
   logic [DIM_W-1:0]      v_cnt, u_cnt, r_cnt;
   logic [UB_ADDR_W-1:0]  ub_base, ub_addr;
   logic [ACC_ADDR_W-1:0] acc_row, acc_addr;
   acc_ent_t              dly [PIPE_LAT];
   logic                  mac_q;
   logic                  rd_fire, last_row, last_u, last_v, upstream_pending, zero_dim;
   logic [ACC_ADDR_W-1:0] rows_acc;

   assign rd_fire  = (state == STREAM) && !bus.stall_i;
   assign last_row = (r_cnt == rows - DIM_W'(1));
   assign last_u   = (u_cnt == u_tiles - DIM_W'(1));
   assign last_v   = (v_cnt == v_tiles - DIM_W'(1));
   assign zero_dim = (bus.v_tiles_i == '0) || (bus.u_tiles_i == '0) || (bus.rows_i == '0);
   assign rows_acc = ACC_ADDR_W'(rows);

   // Entries still travelling ahead of the output stage; the output stage itself retires this cycle unless stalled
   always_comb begin
      upstream_pending = 1'b0;
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
         upstream_pending = upstream_pending | dly[i].valid;
      end
   end

   // Control FSM with running address adders (v outer, u middle, r inner)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         v_tiles  <= '0;
         u_tiles  <= '0;
         rows     <= '0;
         v_cnt    <= '0;
         u_cnt    <= '0;
         r_cnt    <= '0;
         ub_base  <= '0;
         ub_addr  <= '0;
         acc_row  <= '0;
         acc_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  v_tiles  <= bus.v_tiles_i;
                  u_tiles  <= bus.u_tiles_i;
                  rows     <= bus.rows_i;
                  v_cnt    <= '0;
                  u_cnt    <= '0;
                  r_cnt    <= '0;
                  ub_base  <= bus.ub_base_i;
                  ub_addr  <= bus.ub_base_i;
                  acc_row  <= bus.acc_base_i;
                  acc_addr <= bus.acc_base_i;
                  state    <= zero_dim ? DONE : WAIT_W;
               end
            end
            WAIT_W: begin
               if (bus.weight_rdy_i) state <= STREAM;
            end
            STREAM: begin
               if (!bus.stall_i) begin
                  if (!last_row) begin
                     r_cnt    <= r_cnt + DIM_W'(1);
                     ub_addr  <= ub_addr + UB_ADDR_W'(1);
                     acc_addr <= acc_addr + ACC_ADDR_W'(1);
                  end else begin
                     r_cnt <= '0;
                     if (last_u && last_v) begin
                        state <= DRAIN;
                     end else begin
                        state <= WAIT_W;
                        if (last_u) begin
                           // New output column: activations are reused, accumulator moves on by R rows
                           u_cnt    <= '0;
                           v_cnt    <= v_cnt + DIM_W'(1);
                           ub_addr  <= ub_base;
                           acc_row  <= acc_row + rows_acc;
                           acc_addr <= acc_row + rows_acc;
                        end else begin
                           // Next reduction tile: UB rows are contiguous, accumulator rows repeat
                           u_cnt    <= u_cnt + DIM_W'(1);
                           ub_addr  <= ub_addr + UB_ADDR_W'(1);
                           acc_addr <= acc_row;
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (!bus.stall_i && !upstream_pending) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Write delay line matching the systolic pipeline; frozen as a whole while stalled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mac_q <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
      end else begin
         mac_q <= rd_fire;
         if (!bus.stall_i) begin
            dly[0] <= rd_fire ? {1'b1, acc_addr, (u_cnt != '0)} : '0;
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
         end
      end
   end

   assign bus.weight_req_o  = (state == WAIT_W);
   assign bus.ub_rd_en_o    = rd_fire;
   assign bus.ub_addr_o     = ub_addr;
   assign bus.mac_compute_o = mac_q;
   assign bus.acc_wr_en_o   = dly[PIPE_LAT-1].valid && !bus.stall_i;
   assign bus.acc_addr_o    = dly[PIPE_LAT-1].addr;
   assign bus.acc_add_o     = dly[PIPE_LAT-1].add;
   assign bus.busy_o        = (state != IDLE);
   assign bus.done_o        = (state == DONE);
endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer: scoreboard of expected UB reads and accumulator writes.
// Latency: each write is checked to land exactly PIPE_LAT unstalled cycles after its read.
// Backpressure: weight_rdy_i answers each request after two cycles; stall_i is injected on demand.
module tb_tile_sequencer;
   localparam int DIM_W    = 7;
   localparam int UB_W     = 12;
   localparam int ACC_W    = 10;
   localparam int PIPE_LAT = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tile_sequencer_if #(.DIM_W(DIM_W), .UB_ADDR_W(UB_W), .ACC_ADDR_W(ACC_W)) bus ();

   tile_sequencer #(
      .MUL_SIZE(16), .DIM_W(DIM_W), .UB_ADDR_W(UB_W), .ACC_ADDR_W(ACC_W), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state
   logic [UB_W-1:0] rd_q[$];
   logic [ACC_W:0]  wr_q[$];
   int              rd_act_q[$];
   int              act_cnt     = 0;
   int              last_wr_cyc = 0;
   bit              mon_en      = 1'b0;
   logic            prev_rd     = 1'b0;

   // Output monitor: pops expected reads/writes and checks write latency in unstalled cycles
   initial forever begin
      logic [UB_W-1:0] exp_rd;
      logic [ACC_W:0]  exp_wr;
      int              a;
      @(negedge clk);
      if (mon_en) begin
         checks++;
         if (bus.mac_compute_o !== prev_rd) begin
            errors++;
            $display("FAIL mac_compute: got %b want %b (cycle %0d)", bus.mac_compute_o, prev_rd, cyc);
         end
         if (bus.ub_rd_en_o === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_read: got addr %03h want no read (cycle %0d)", bus.ub_addr_o, cyc);
            end else begin
               exp_rd = rd_q.pop_front();
               if (bus.ub_addr_o !== exp_rd) begin
                  errors++;
                  $display("FAIL ub_addr: got %03h want %03h (cycle %0d)", bus.ub_addr_o, exp_rd, cyc);
               end
            end
            rd_act_q.push_back(act_cnt);
         end
         if (bus.stall_i === 1'b1) begin
            checks++;
            if (bus.acc_wr_en_o !== 1'b0) begin
               errors++;
               $display("FAIL wr_during_stall: got %b want 0 (cycle %0d)", bus.acc_wr_en_o, cyc);
            end
         end
         if (bus.acc_wr_en_o === 1'b1) begin
            last_wr_cyc = cyc;
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr %03h want no write (cycle %0d)", bus.acc_addr_o, cyc);
            end else begin
               exp_wr = wr_q.pop_front();
               if ({bus.acc_addr_o, bus.acc_add_o} !== exp_wr) begin
                  errors++;
                  $display("FAIL acc_write: got addr %03h add %b want addr %03h add %b (cycle %0d)",
                           bus.acc_addr_o, bus.acc_add_o, exp_wr[ACC_W:1], exp_wr[0], cyc);
               end
            end
            checks++;
            if (rd_act_q.size() == 0) begin
               errors++;
               $display("FAIL write_latency: got write with no read want matching read (cycle %0d)", cyc);
            end else begin
               a = rd_act_q.pop_front();
               if (act_cnt - a !== PIPE_LAT) begin
                  errors++;
                  $display("FAIL write_latency: got %0d want %0d (cycle %0d)", act_cnt - a, PIPE_LAT, cyc);
               end
            end
         end
         if (bus.stall_i !== 1'b1) act_cnt++;
         prev_rd = rst ? 1'b0 : bus.ub_rd_en_o;
      end
   end

   // Runs one command to completion: pushes expectations, answers weight requests, injects stalls
   task automatic drive_cmd(input int v, input int u, input int r, input int ub, input int acc,
                            input int stall_after, input int stall_len, input int spurious_at,
                            output int reqs, output int start_cyc, output int done_cyc,
                            output bit timed_out);
      int wcnt, scnt, rcount;
      bit stalled;
      for (int vi = 0; vi < v; vi++)
         for (int ui = 0; ui < u; ui++)
            for (int ri = 0; ri < r; ri++) begin
               rd_q.push_back(UB_W'(ub + ui * r + ri));
               wr_q.push_back({ACC_W'(acc + vi * r + ri), ui != 0});
            end
      reqs = 0; done_cyc = -1; timed_out = 1'b1; wcnt = -1; scnt = 0; rcount = 0; stalled = 1'b0;
      @(posedge clk); #1;
      bus.v_tiles_i  = DIM_W'(v);
      bus.u_tiles_i  = DIM_W'(u);
      bus.rows_i     = DIM_W'(r);
      bus.ub_base_i  = UB_W'(ub);
      bus.acc_base_i = ACC_W'(acc);
      bus.start_i    = 1'b1;
      start_cyc      = cyc;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) begin
            done_cyc  = cyc;
            timed_out = 1'b0;
            break;
         end
         if (bus.ub_rd_en_o === 1'b1) rcount++;
         if (bus.weight_req_o === 1'b1 && wcnt < 0 && bus.weight_rdy_i !== 1'b1) begin
            reqs++;
            wcnt = 1;
         end
         if (stall_after > 0 && !stalled && rcount == stall_after) begin
            stalled = 1'b1;
            scnt    = stall_len;
         end
         @(posedge clk); #1;
         bus.start_i = (k == spurious_at);
         if (wcnt == 0) begin
            bus.weight_rdy_i = 1'b1;
            wcnt = -1;
         end else begin
            bus.weight_rdy_i = 1'b0;
            if (wcnt > 0) wcnt--;
         end
         if (scnt > 0) begin
            bus.stall_i = 1'b1;
            scnt--;
         end else begin
            bus.stall_i = 1'b0;
         end
      end
      bus.start_i = 1'b0; bus.weight_rdy_i = 1'b0; bus.stall_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.done_o, bus.weight_req_o, bus.ub_rd_en_o, bus.mac_compute_o,
           bus.acc_wr_en_o, bus.acc_add_o} !== 7'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 0000000", {bus.busy_o, bus.done_o, bus.weight_req_o,
                  bus.ub_rd_en_o, bus.mac_compute_o, bus.acc_wr_en_o, bus.acc_add_o});
      end
      checks++;
      if ({bus.ub_addr_o, bus.acc_addr_o} !== '0) begin
         errors++;
         $display("FAIL reset_addrs: got ub %03h acc %03h want 0 0", bus.ub_addr_o, bus.acc_addr_o);
      end
      @(posedge clk); #1;
      rst     = 1'b0;
      prev_rd = 1'b0;
      mon_en  = 1'b1;
   endtask

   task automatic test_single_tile();
      int reqs, sc, dc;
      bit to;
      drive_cmd(1, 1, 4, 'h010, 'h020, 0, 0, -1, reqs, sc, dc, to);
      checks++;
      if (to) begin errors++; $display("FAIL single_timeout: got no done want done"); end
      checks++;
      if (reqs !== 1) begin errors++; $display("FAIL single_reqs: got %0d want 1", reqs); end
      checks++;
      if (dc - last_wr_cyc !== 1) begin
         errors++; $display("FAIL single_done_gap: got %0d want 1", dc - last_wr_cyc);
      end
      checks++;
      if (rd_q.size() + wr_q.size() !== 0) begin
         errors++; $display("FAIL single_leftover: got %0d want 0", rd_q.size() + wr_q.size());
      end
   endtask

   task automatic test_multi_tile();
      int reqs, sc, dc;
      bit to;
      drive_cmd(2, 2, 3, 0, 0, 0, 0, -1, reqs, sc, dc, to);
      checks++;
      if (to) begin errors++; $display("FAIL multi_timeout: got no done want done"); end
      checks++;
      if (reqs !== 4) begin errors++; $display("FAIL multi_reqs: got %0d want 4", reqs); end
      checks++;
      if (rd_q.size() + wr_q.size() !== 0) begin
         errors++; $display("FAIL multi_leftover: got %0d want 0", rd_q.size() + wr_q.size());
      end
   endtask

   task automatic test_stall();
      int reqs, sc, dc;
      bit to;
      drive_cmd(1, 1, 4, 'h010, 'h020, 2, 5, -1, reqs, sc, dc, to);
      checks++;
      if (to) begin errors++; $display("FAIL stall_timeout: got no done want done"); end
      checks++;
      if (dc - last_wr_cyc !== 1) begin
         errors++; $display("FAIL stall_done_gap: got %0d want 1", dc - last_wr_cyc);
      end
      checks++;
      if (rd_q.size() + wr_q.size() !== 0) begin
         errors++; $display("FAIL stall_leftover: got %0d want 0", rd_q.size() + wr_q.size());
      end
   endtask

   task automatic test_zero_dims();
      int reqs, sc, dc;
      bit to;
      int dims[3][3] = '{'{1, 0, 4}, '{2, 2, 0}, '{0, 1, 1}};
      for (int i = 0; i < 3; i++) begin
         drive_cmd(dims[i][0], dims[i][1], dims[i][2], 'h040, 'h050, 0, 0, -1, reqs, sc, dc, to);
         checks++;
         if (to || dc - sc !== 1) begin
            errors++; $display("FAIL zero_done_%0d: got gap %0d timeout %b want 1 0", i, dc - sc, to);
         end
         checks++;
         if (reqs !== 0) begin errors++; $display("FAIL zero_reqs_%0d: got %0d want 0", i, reqs); end
      end
   endtask

   task automatic test_wrap();
      int reqs, sc, dc;
      bit to;
      drive_cmd(1, 1, 4, 'hFFE, 'h3FF, 0, 0, -1, reqs, sc, dc, to);
      checks++;
      if (to || rd_q.size() + wr_q.size() !== 0) begin
         errors++; $display("FAIL wrap_complete: got leftover %0d timeout %b want 0 0",
                            rd_q.size() + wr_q.size(), to);
      end
   endtask

   task automatic test_reset_mid();
      int n, dones;
      bit ok;
      for (int ri = 0; ri < 8; ri++) begin
         rd_q.push_back(UB_W'('h100 + ri));
         wr_q.push_back({ACC_W'('h040 + ri), 1'b0});
      end
      @(posedge clk); #1;
      bus.v_tiles_i = 1; bus.u_tiles_i = 1; bus.rows_i = 8;
      bus.ub_base_i = 'h100; bus.acc_base_i = 'h040; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      n = 0; ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.ub_rd_en_o === 1'b1) n++;
         if (n == 3) begin ok = 1'b1; break; end
         @(posedge clk); #1;
         bus.weight_rdy_i = (bus.weight_req_o === 1'b1);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_reads: got %0d reads want 3", n); end
      @(posedge clk); #1;
      rst = 1'b1; bus.weight_rdy_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      rd_q.delete(); wr_q.delete(); rd_act_q.delete();
      @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.done_o, bus.weight_req_o, bus.ub_rd_en_o, bus.mac_compute_o,
           bus.acc_wr_en_o, bus.acc_add_o} !== 7'b0) begin
         errors++;
         $display("FAIL rstmid_strobes: got %b want 0000000", {bus.busy_o, bus.done_o, bus.weight_req_o,
                  bus.ub_rd_en_o, bus.mac_compute_o, bus.acc_wr_en_o, bus.acc_add_o});
      end
      checks++;
      if ({bus.ub_addr_o, bus.acc_addr_o} !== '0) begin
         errors++;
         $display("FAIL rstmid_addrs: got ub %03h acc %03h want 0 0", bus.ub_addr_o, bus.acc_addr_o);
      end
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) dones++;
      end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL rstmid_idle: got %0d active cycles want 0", dones); end
   endtask

   task automatic test_start_ignored();
      int reqs, sc, dc;
      bit to;
      drive_cmd(1, 2, 2, 'h020, 'h008, 0, 0, 3, reqs, sc, dc, to);
      checks++;
      if (to || reqs !== 2) begin
         errors++; $display("FAIL busy_start_reqs: got %0d timeout %b want 2 0", reqs, to);
      end
      checks++;
      if (rd_q.size() + wr_q.size() !== 0) begin
         errors++; $display("FAIL busy_start_leftover: got %0d want 0", rd_q.size() + wr_q.size());
      end
   endtask

   initial begin
      bus.start_i = 1'b0; bus.v_tiles_i = '0; bus.u_tiles_i = '0; bus.rows_i = '0;
      bus.ub_base_i = '0; bus.acc_base_i = '0; bus.weight_rdy_i = 1'b0; bus.stall_i = 1'b0;
      test_reset();
      test_single_tile();
      test_multi_tile();
      test_stall();
      test_zero_dims();
      test_wrap();
      test_reset_mid();
      test_start_ignored();
      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
